// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline sequencer: latch commands and FSM states.
// Optional HAZARD_PERF_EN build adds performance counters to the top.
package cpu_types_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        HALTED   = 2'd3
    } hzd_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: an EX-stage load writing a register that the
// ID-stage instruction reads. Register 0 is never a hazard.
module hazard_detect
    import cpu_types_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              i_mem_to_reg_ex,
    input  logic [REG_AW-1:0] i_wsel_ex,
    input  logic [REG_AW-1:0] i_rs_id,
    input  logic [REG_AW-1:0] i_rt_id,
    output logic              o_lu
);

    logic w_nz;
    logic w_match;

    // Compare the load destination against both ID sources
    always_comb begin
        w_nz    = (i_wsel_ex != '0);
        w_match = (i_wsel_ex == i_rs_id) || (i_wsel_ex == i_rt_id);
        o_lu    = i_mem_to_reg_ex && w_nz && w_match;
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central pipeline sequencer: latch commands, PC enable and fetch request.
// Define HAZARD_PERF_EN to add stall_cycles / flush_count counters.
module pipeline_hazard_controller
    import cpu_types_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dREN_mem,
    input  logic              dWEN_mem,
    input  logic              PCSrc_mem,
    input  logic              halt_mem,
    input  logic              MemToReg_ex,
    input  logic [REG_AW-1:0] regWSEL_ex,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count,
`endif
    output logic              pc_en,
    output logic              iREN,
    output pipe_state_t       fd_state,
    output pipe_state_t       de_state,
    output pipe_state_t       em_state,
    output pipe_state_t       mw_state
);

    hzd_state_t r_state;
    hzd_state_t w_next;
    logic       w_lu;
    logic       w_memop;
    logic       w_dwait;
    logic       w_redir_ok;
    logic       w_flush_hit;

    hazard_detect #(
        .REG_AW(REG_AW)
    ) u_hd (
        .i_mem_to_reg_ex(MemToReg_ex),
        .i_wsel_ex      (regWSEL_ex),
        .i_rs_id        (rs_id),
        .i_rt_id        (rt_id),
        .o_lu           (w_lu)
    );

    assign w_memop    = dREN_mem | dWEN_mem;
    assign w_dwait    = w_memop & ~dhit;
    assign w_redir_ok = (r_state != FLUSH);

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= RUN;
        else       r_state <= w_next;
    end

    // Next state and latch commands by fixed priority
    always_comb begin
        w_next      = r_state;
        pc_en       = 1'b0;
        iREN        = 1'b0;
        fd_state    = PIPE_NOP;
        de_state    = PIPE_NOP;
        em_state    = PIPE_NOP;
        mw_state    = PIPE_NOP;
        w_flush_hit = 1'b0;
        if (nRST) begin
            if (r_state == HALTED) begin
                fd_state = PIPE_STALL;
                de_state = PIPE_STALL;
                em_state = PIPE_STALL;
                mw_state = PIPE_STALL;
            end else if (r_state == FLUSH && !ihit) begin
                iREN     = 1'b1;
                de_state = PIPE_ENABLE;
                em_state = PIPE_ENABLE;
                mw_state = PIPE_ENABLE;
            end else begin
                iREN = 1'b1;
                if (halt_mem && !w_dwait) begin
                    mw_state = PIPE_ENABLE;
                    w_next   = HALTED;
                end else if (w_dwait) begin
                    fd_state = PIPE_STALL;
                    de_state = PIPE_STALL;
                    em_state = PIPE_STALL;
                    w_next   = MEM_WAIT;
                end else if (PCSrc_mem && w_redir_ok) begin
                    pc_en       = 1'b1;
                    mw_state    = PIPE_ENABLE;
                    w_next      = FLUSH;
                    w_flush_hit = 1'b1;
                end else if (w_lu) begin
                    fd_state = PIPE_STALL;
                    em_state = PIPE_ENABLE;
                    mw_state = PIPE_ENABLE;
                    w_next   = RUN;
                end else if (!ihit) begin
                    de_state = PIPE_ENABLE;
                    em_state = PIPE_ENABLE;
                    mw_state = PIPE_ENABLE;
                    w_next   = RUN;
                end else begin
                    pc_en    = 1'b1;
                    fd_state = PIPE_ENABLE;
                    de_state = PIPE_ENABLE;
                    em_state = PIPE_ENABLE;
                    mw_state = PIPE_ENABLE;
                    w_next   = RUN;
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall;
    logic [31:0] r_flush;

    // Saturating stall-cycle and flush counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (!pc_en && r_state != HALTED && r_stall != '1)
                r_stall <= r_stall + 32'd1;
            if (w_flush_hit && r_flush != '1)
                r_flush <= r_flush + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
    assign flush_count  = r_flush;
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage pipeline.
- Each cycle it issues a pipe-state command (PIPE_ENABLE / PIPE_STALL / PIPE_NOP) to each of the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB), plus the PC enable.
- Resolves these conditions by fixed priority: halt, data-memory wait, taken branch/jump flush, load-use hazard, instruction-memory wait.
- Owns a small FSM that tracks multi-cycle conditions (memory wait, post-flush refetch, halted).

Parameters:
- REG_AW, 5, register-select width used in hazard compares.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory returned data this cycle
- dhit  in  1  data memory completed access this cycle
- dREN_mem  in  1  MEM-stage load in flight
- dWEN_mem  in  1  MEM-stage store in flight
- PCSrc_mem  in  1  MEM-stage branch/jump taken (redirect)
- halt_mem  in  1  MEM-stage halt instruction
- MemToReg_ex  in  1  EX-stage instruction is a load
- regWSEL_ex  in  REG_AW  EX-stage destination register
- rs_id  in  REG_AW  ID-stage source register 1
- rt_id  in  REG_AW  ID-stage source register 2
- pc_en  out  1  PC register update enable
- iREN  out  1  instruction fetch request
- fd_state  out  2  IF/ID latch command (pipe_state_t)
- de_state  out  2  ID/EX latch command
- em_state  out  2  EX/MEM latch command
- mw_state  out  2  MEM/WB latch command

Behaviour:
- Clocking/reset: single clock CLK; reset nRST is asynchronous, active-low.
- FSM state register: RUN, MEM_WAIT, FLUSH, HALTED. Reset value RUN.
- Outputs are combinational from state + inputs. While nRST=0, all latch commands are PIPE_NOP and pc_en=0, iREN=0.
- Derived terms:
  - memop = dREN_mem | dWEN_mem
  - lu = MemToReg_ex & (regWSEL_ex != 0) & (regWSEL_ex == rs_id | regWSEL_ex == rt_id)
- RUN and MEM_WAIT evaluate the same priority list, first match wins:
  1. halt_mem & !(memop & !dhit): pc_en=0; fd/de/em=NOP; mw=ENABLE. Next state HALTED.
  2. memop & !dhit: pc_en=0; fd/de/em=STALL; mw=NOP. Next state MEM_WAIT.
  3. PCSrc_mem: pc_en=1; fd/de/em=NOP; mw=ENABLE. Next state FLUSH.
  4. lu: pc_en=0; fd=STALL; de=NOP; em/mw=ENABLE. Next state RUN.
  5. !ihit: pc_en=0; fd=NOP; de/em/mw=ENABLE. Next state RUN.
  6. Otherwise: all ENABLE, pc_en=1. Next state RUN.
- FLUSH: waits for the redirected fetch.
  - !ihit: pc_en=0; fd=NOP; de/em/mw=ENABLE; stay in FLUSH.
  - ihit: evaluate the RUN list, except that rule 3 is ignored (the redirect is already applied).
- HALTED: all latches STALL, pc_en=0, iREN=0. Exit only via reset.
- iREN=1 in RUN, MEM_WAIT and FLUSH.
- Boundary cases:
  - ihit and dhit both high: dhit resolves rule 2 first; ihit is then used by rule 5.
  - PCSrc_mem during a pending dmem access: the redirect waits in MEM_WAIT; it is taken on the dhit cycle because the EX/MEM latch is held.
  - Load-use with regWSEL_ex=0: never a hazard.
  - Reset mid-MEM_WAIT or in HALTED: returns to RUN immediately (asynchronous).

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs stall_cycles [31:0] and flush_count [31:0], both reset to 0.
  - stall_cycles increments on every cycle with pc_en=0 and state != HALTED.
  - flush_count increments on every rule-3 match.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg holds:
  - pipe_state_t enum {PIPE_ENABLE, PIPE_STALL, PIPE_NOP}, 2 bits
  - hzd_state_t enum {RUN, MEM_WAIT, FLUSH, HALTED}
  - REG_AW default
- One sub-module: hazard_detect. It is pure combinational and computes lu from rs_id/rt_id/regWSEL_ex/MemToReg_ex.
- The FSM and command mapping stay in the top module.

Test Plan:
- Reset: hold nRST=0 for 3 cycles with ihit=1. Required: all states NOP, pc_en=0. Release → RUN, all ENABLE, pc_en=1.
- Load-use: MemToReg_ex=1, regWSEL_ex=5, rt_id=5, ihit=1. Required: fd=STALL, de=NOP, pc_en=0 for exactly 1 cycle. Repeat with regWSEL_ex=0 → no stall.
- Dmem wait: dREN_mem=1, dhit=0 for 4 cycles, then dhit=1. Required: 4 cycles of fd/de/em=STALL, mw=NOP, state MEM_WAIT; then all ENABLE and RUN.
- Branch flush: PCSrc_mem=1 one cycle, then ihit=0 for 2 cycles, then ihit=1. Required: fd/de/em=NOP with pc_en=1; then 2 cycles fd=NOP with pc_en=0; then RUN.
- Halt: halt_mem=1 with memop=0. Required: mw=ENABLE, others NOP, then HALTED with all STALL indefinitely. Asserting nRST=0 mid-HALTED → RUN after release.
- HAZARD_PERF_EN: 4-cycle dmem wait plus 1 flush. Required: stall_cycles=4 (plus refetch cycles), flush_count=1.
